seq_detect_param: RTL and testbench

Parametrised serial pattern detector: the generalised successor to the fixed 3-bit "101" Mealy detector. It detects a run-time-loadable PAT_W-bit pattern on a qualified serial bit stream. Overlap and output style (Mealy or Moore) are selected at run time, and a saturating match counter is included. It sits on the serial receive path and drives frame-sync and marker-detect logic.

---
 rtl/seq_detect_param.sv | 101 ++++++++++
 tb/tb_seq_detect_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module  : seq_detect_param
// Brief   : Run-time loadable serial pattern detector with prefix-length
//           fallback, selectable overlap / Mealy-Moore output, match counter.
// Revision: 1.0 - initial release
// ============================================================================
module seq_detect_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = 8,
  parameter int               SW      = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_valid,
  input  logic             seq_in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap_en,
  input  logic             moore_mode,
  input  logic             clr_cnt,
  output logic             seq_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [SW-1:0]    crnt_state
);

  localparam logic [PAT_W-1:0] c_ones    = {PAT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [SW-1:0]    c_last    = SW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  logic [PAT_W-1:0] pfx;
  logic [PAT_W-1:0] s_val;
  logic [SW-1:0]    fb;
  logic [SW-1:0]    bord;
  logic             match;

  // s_val holds the matched prefix followed by the incoming bit, LSB-aligned
  always_comb begin
    pfx   = pat_q >> (PAT_W - int'(state_q));
    s_val = (pfx << 1) | PAT_W'(seq_in);
    match = seq_valid & ~pat_load & (state_q == c_last) & (s_val == pat_q);

    fb = '0;
    for (int j = 1; j < PAT_W; j++) begin
      if ((j <= int'(state_q) + 1) &&
          ((s_val & (c_ones >> (PAT_W - j))) == (pat_q >> (PAT_W - j))))
        fb = SW'(j);
    end

    bord = '0;
    for (int j = 1; j < PAT_W; j++) begin
      if ((pat_q & (c_ones >> (PAT_W - j))) == (pat_q >> (PAT_W - j)))
        bord = SW'(j);
    end
  end

  always_comb begin
    pat_d   = pat_q;
    state_d = state_q;
    out_d   = match;
    cnt_d   = cnt_q;

    if (pat_load) begin
      pat_d   = pattern;
      state_d = '0;
    end else if (seq_valid) begin
      if (match) state_d = overlap_en ? bord : '0;
      else       state_d = fb;
    end

    if (clr_cnt)                           cnt_d = match ? CNT_W'(1) : '0;
    else if (match && (cnt_q != c_cnt_max)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= PAT_RST;
      state_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Gate with reset so the Mealy path is quiet while reset is held
  assign seq_out    = reset & (moore_mode ? out_q : match);
  assign match_cnt  = cnt_q;
  assign crnt_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_detect_param
// Brief   : Two detector instances (3-bit / 4-bit) against a history-based
//           reference model, with directed pins and randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset, seq_valid, seq_in, pat_load, overlap_en, moore_mode, clr_cnt;
  logic [3:0] pattern;
  logic       so3, so4;
  logic [1:0] cnt3, st3, st4;
  logic [7:0] cnt4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .seq_valid(seq_valid), .seq_in(seq_in),
    .pat_load(pat_load), .pattern(pattern[2:0]), .overlap_en(overlap_en),
    .moore_mode(moore_mode), .clr_cnt(clr_cnt), .seq_out(so3),
    .match_cnt(cnt3), .crnt_state(st3)
  );

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .seq_valid(seq_valid), .seq_in(seq_in),
    .pat_load(pat_load), .pattern(pattern), .overlap_en(overlap_en),
    .moore_mode(moore_mode), .clr_cnt(clr_cnt), .seq_out(so4),
    .match_cnt(cnt4), .crnt_state(st4)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: pattern plus the recent history of consumed bits
  // (newest in LSB), length capped at the pattern width.
  int pw[2]   = '{3, 4};
  int prst[2] = '{5, 13};
  int cmax[2] = '{3, 255};
  int pat[2], hv[2], hl[2], cnt[2];
  bit outq[2];

  function automatic void model_reset(input int i);
    pat[i] = prst[i]; hv[i] = 0; hl[i] = 0; cnt[i] = 0; outq[i] = 1'b0;
  endfunction

  // Longest history suffix (shorter than the pattern) equal to a pattern prefix
  function automatic int mstate(input int i);
    int lim = (hl[i] < pw[i] - 1) ? hl[i] : pw[i] - 1;
    for (int j = lim; j > 0; j--)
      if ((hv[i] & ((1 << j) - 1)) == (pat[i] >> (pw[i] - j))) return j;
    return 0;
  endfunction

  function automatic bit mmatch(input int i);
    int nv;
    if (!seq_valid || pat_load || !reset) return 1'b0;
    nv = ((hv[i] << 1) | int'(seq_in)) & ((1 << pw[i]) - 1);
    return (hl[i] + 1 >= pw[i]) && (nv == pat[i]);
  endfunction

  function automatic int act_so(input int i);
    return (i == 0) ? int'(so3) : int'(so4);
  endfunction
  function automatic int act_cnt(input int i);
    return (i == 0) ? int'(cnt3) : int'(cnt4);
  endfunction
  function automatic int act_st(input int i);
    return (i == 0) ? int'(st3) : int'(st4);
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) model_reset(i);
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        int es, eo, ec;
        if (!reset) begin
          es = 0; eo = 0; ec = 0;
        end else begin
          es = mstate(i);
          ec = cnt[i];
          eo = moore_mode ? int'(outq[i]) : int'(mmatch(i));
        end
        chk((i == 0) ? "seq_out3" : "seq_out4", act_so(i), eo);
        chk((i == 0) ? "cnt3" : "cnt4", act_cnt(i), ec);
        chk((i == 0) ? "state3" : "state4", act_st(i), es);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        bit m;
        if (!reset) begin
          model_reset(i);
        end else begin
          m = mmatch(i);
          outq[i] = m;
          if (clr_cnt)                 cnt[i] = int'(m);
          else if (m && cnt[i] < cmax[i]) cnt[i]++;
          if (pat_load) begin
            pat[i] = int'(pattern) & ((1 << pw[i]) - 1);
            hv[i] = 0; hl[i] = 0;
          end else if (seq_valid) begin
            if (m && !overlap_en) begin
              hv[i] = 0; hl[i] = 0;
            end else begin
              hv[i] = ((hv[i] << 1) | int'(seq_in)) & ((1 << pw[i]) - 1);
              hl[i] = (hl[i] + 1 < pw[i]) ? hl[i] + 1 : pw[i];
            end
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input bit b, input bit ld, input bit clr);
    @(posedge clk); #1;
    seq_valid = v; seq_in = b; pat_load = ld; clr_cnt = clr;
    @(negedge clk);
  endtask

  task automatic set_mode(input bit ov, input bit mm);
    @(posedge clk); #1;
    overlap_en = ov; moore_mode = mm;
    seq_valid = 1'b0; pat_load = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int so_t1[5] = '{0, 0, 1, 0, 1};
    int st_t1[5] = '{0, 1, 2, 1, 2};
    int so_t2[5] = '{0, 0, 1, 0, 0};
    int b_t3[7]  = '{1, 1, 0, 1, 1, 0, 1};
    int so_t3[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    int c_t5[14] = '{-1, -1, -1, 1, -1, 2, -1, 3, -1, 3, -1, 1, -1, 2};
    int rst_hold = 0;

    reset = 1'b0; seq_valid = 1'b0; seq_in = 1'b0; pat_load = 1'b0;
    overlap_en = 1'b1; moore_mode = 1'b0; clr_cnt = 1'b0; pattern = 4'b1101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt3", int'(cnt3), 0);
    chk("rst_st3", int'(st3), 0);
    chk("rst_so3", int'(so3), 0);
    @(posedge clk); #1 reset = 1'b1;

    // 101 overlapping, Mealy
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, so_t1[n][0] | (n % 2 == 0), 1'b0, 1'b0);
      chk("t1_so3", int'(so3), so_t1[n]);
      chk("t1_st3", int'(st3), st_t1[n]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_cnt3", int'(cnt3), 2);
    chk("t1_st3_end", int'(st3), 1);

    // 101 non-overlapping
    set_mode(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, (n % 2 == 0), 1'b0, 1'b0);
      chk("t2_so3", int'(so3), so_t2[n]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_cnt3", int'(cnt3), 3);
    chk("t2_st3_end", int'(st3), 1);

    // 1101 overlapping, Moore
    set_mode(1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      if (n < 7) drive(1'b1, b_t3[n][0], 1'b0, 1'b0);
      else       drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_so4", int'(so4), so_t3[n]);
      if (n == 4 || n == 7) chk("t3_st4", int'(st4), 1);
    end
    chk("t3_cnt4", int'(cnt4), 2);

    // 101 with valid gaps, Mealy
    set_mode(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_st_gap1", int'(st3), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_so_gap", int'(so3), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_st_gap2", int'(st3), 2);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_so3", int'(so3), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_cnt3", int'(cnt3), 1);

    // Counter saturation at 3, clear on the fifth match
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      if (n < 14) drive(1'b1, (n % 2 == 1), 1'b0, (n == 11));
      else        drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (c_t5[n-1] >= 0) chk("t5_cnt3", int'(cnt3), c_t5[n-1]);
      if (n == 9) chk("t5_so3_sat", int'(so3), 1);
    end

    // Asynchronous reset mid-pattern
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; seq_valid = 1'b1; seq_in = 1'b1;
    @(negedge clk);
    chk("t6_so3_rst", int'(so3), 0);
    chk("t6_cnt3_rst", int'(cnt3), 0);
    chk("t6_st3_rst", int'(st3), 0);
    @(posedge clk); #1 seq_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_so3_b1", int'(so3), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_so3_b3", int'(so3), 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (rst_hold > 0) begin
        rst_hold--;
        reset = (rst_hold == 0);
      end else if ($urandom_range(299) == 0) begin
        rst_hold = 2;
        reset = 1'b0;
      end
      seq_valid = ($urandom_range(3) != 0);
      seq_in    = 1'($urandom_range(1));
      pat_load  = ($urandom_range(39) == 0);
      clr_cnt   = ($urandom_range(49) == 0);
      case ($urandom_range(7))
        0:       pattern = 4'b1111;
        1:       pattern = 4'b0000;
        default: pattern = 4'($urandom_range(15));
      endcase
      if ($urandom_range(99) == 0) overlap_en = ~overlap_en;
      if ($urandom_range(79) == 0) moore_mode = ~moore_mode;
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
